// File: rtl/led_flash_pkg.sv
// Shared types and constants for the LED flash sequencer.
//   state_t  : sequencer FSM states (IDLE, RUN)
//   mode_t   : pattern select encodings as seen on the mode pins
//   speed_t  : step-rate select encodings as seen on the speed pins
//   dir_t    : ping-pong travel direction
//   PAT_*    : pattern constants, init_pattern() gives the first frame per mode
package led_flash_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_ROL   = 2'd0,
        MODE_ROR   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PING  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SPD_SLOW  = 2'd0,
        SPD_MID   = 2'd1,
        SPD_FAST  = 2'd2,
        SPD_TURBO = 2'd3
    } speed_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] PAT_LOW  = 8'h01;
    localparam logic [7:0] PAT_HIGH = 8'h80;
    localparam logic [7:0] PAT_ALL  = 8'hFF;

    function automatic logic [7:0] init_pattern(input mode_t m);
        logic [7:0] p;
        unique case (m)
            MODE_ROL:   p = PAT_LOW;
            MODE_ROR:   p = PAT_HIGH;
            MODE_BLINK: p = PAT_ALL;
            MODE_PING:  p = PAT_LOW;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_flash_ctrl_step_timer.sv
// Modulo-n step counter.
//   clk   : system clock
//   rst   : synchronous active-high reset, count -> 0
//   clear : synchronous clear, count -> 0 (overrides en)
//   en    : count enable
//   n     : modulus; count runs 0..n-1
//   tick  : combinational, high while enabled and count == n-1
module step_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] n,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    assign tick = en && (count == (n - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/led_flash_ctrl.sv
// LED flash sequencer for the 8-LED board. A step_timer produces one enable
// tick every Nsel cycles; on each tick the current pattern advances one frame.
//   clk       : system clock (only clock in the block)
//   rst       : synchronous active-high reset
//   start     : pulse, latch mode/speed and (re)start the sequence
//   stop      : pulse, end sequence and blank LEDs (wins over start)
//   mode      : 0 rotate-left, 1 rotate-right, 2 blink-all, 3 ping-pong
//   speed     : step-rate select (N_SLOW/N_MID/N_FAST/N_TURBO)
//   led       : registered LED drive, 1 = lit
//   busy      : high while running
//   step_tick : registered pulse coincident with each pattern advance
module led_flash_ctrl
    import led_flash_pkg::*;
#(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned N_SLOW  = 12_000_000,
    parameter int unsigned N_MID   = 6_000_000,
    parameter int unsigned N_FAST  = 3_000_000,
    parameter int unsigned N_TURBO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic       busy,
    output logic       step_tick
);

    localparam logic [WIDTH-1:0] NW_SLOW  = WIDTH'(N_SLOW);
    localparam logic [WIDTH-1:0] NW_MID   = WIDTH'(N_MID);
    localparam logic [WIDTH-1:0] NW_FAST  = WIDTH'(N_FAST);
    localparam logic [WIDTH-1:0] NW_TURBO = WIDTH'(N_TURBO);

    state_t           state, state_n;
    mode_t            mode_r, mode_n;
    speed_t           speed_r, speed_n;
    speed_t           speed_pend;
    dir_t             dir, dir_n;
    logic [7:0]       led_n;
    logic             busy_n;
    logic             tick_n;
    logic [WIDTH-1:0] n_sel;
    logic             timer_tick;
    logic             timer_clear;

    always_comb begin
        n_sel = NW_SLOW;
        unique case (speed_r)
            SPD_SLOW:  n_sel = NW_SLOW;
            SPD_MID:   n_sel = NW_MID;
            SPD_FAST:  n_sel = NW_FAST;
            SPD_TURBO: n_sel = NW_TURBO;
        endcase
    end

    // Counter sits at zero in IDLE and restarts on every start/stop pulse.
    assign timer_clear = (state == IDLE) || start || stop;

    step_timer #(.WIDTH(WIDTH)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .en    (state == RUN),
        .n     (n_sel),
        .tick  (timer_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            led        <= '0;
            busy       <= 1'b0;
            step_tick  <= 1'b0;
            mode_r     <= MODE_ROL;
            speed_r    <= SPD_SLOW;
            speed_pend <= SPD_SLOW;
            dir        <= DIR_LEFT;
        end else begin
            state      <= state_n;
            led        <= led_n;
            busy       <= busy_n;
            step_tick  <= tick_n;
            mode_r     <= mode_n;
            speed_r    <= speed_n;
            speed_pend <= speed_t'(speed);
            dir        <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = led;
        dir_n   = dir;
        mode_n  = mode_r;
        speed_n = speed_r;
        tick_n  = 1'b0;

        if (stop) begin
            state_n = IDLE;
            led_n   = '0;
        end else if (start) begin
            state_n = RUN;
            mode_n  = mode_t'(mode);
            speed_n = speed_t'(speed);
            dir_n   = DIR_LEFT;
            led_n   = init_pattern(mode_t'(mode));
        end else if (state == RUN && timer_tick) begin
            tick_n  = 1'b1;
            // New rate only takes effect once the running step has finished.
            speed_n = speed_pend;
            unique case (mode_r)
                MODE_ROL:   led_n = {led[6:0], led[7]};
                MODE_ROR:   led_n = {led[0], led[7:1]};
                MODE_BLINK: led_n = ~led;
                MODE_PING: begin
                    // Direction flips on the frame that lights the end LED,
                    // so the ends are shown once per sweep.
                    if (dir == DIR_LEFT) begin
                        led_n = {led[6:0], 1'b0};
                        if (led_n == PAT_HIGH) dir_n = DIR_RIGHT;
                    end else begin
                        led_n = {1'b0, led[7:1]};
                        if (led_n == PAT_LOW) dir_n = DIR_LEFT;
                    end
                end
            endcase
        end

        busy_n = (state_n == RUN);
    end

endmodule

// File: doc/led_flash_ctrl.md
Name: led_flash_ctrl

Overview:
Sequencer for the 8-LED flash board. An internal modulo-N step timer produces a one-cycle enable tick; this replaces the divided-clock approach, and all logic stays on the single system clock. On each tick a small FSM advances one of four LED patterns. Speed is selectable at runtime and applied glitch-free at step boundaries. The block sits between the board switches/buttons and the LED pins.

Parameters:
WIDTH, 24, step-counter width; every N_* below must be < 2**WIDTH
N_SLOW, 12_000_000, clk cycles per step for speed 0 (1 s at 12 MHz)
N_MID, 6_000_000, cycles per step for speed 1
N_FAST, 3_000_000, cycles per step for speed 2
N_TURBO, 4, cycles per step for speed 3 (bench/bring-up rate)

Ports:
clk  in  1  system clock, 12 MHz, only clock in the block
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: latch mode/speed, begin or restart sequence
stop  in  1  single-cycle pulse: end sequence, blank LEDs
mode  in  2  0 rotate-left, 1 rotate-right, 2 blink-all, 3 ping-pong
speed  in  2  selects N_SLOW/N_MID/N_FAST/N_TURBO
led  out  8  LED drive, registered, 1 = lit
busy  out  1  high while in RUN
step_tick  out  1  registered one-cycle pulse, coincident with each led pattern advance

Behaviour:
- Reset (rst high at posedge): state IDLE; led=8'h00, busy=0, step_tick=0; counter=0, mode/speed registers=0, dir=left.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN on start. RUN -> IDLE on stop. start in RUN restarts the sequence.
- stop and start in the same cycle: stop wins (goes to or stays in IDLE).
- On start at edge k:
  - mode_r <= mode, speed_r <= speed, counter <= 0, dir <= left.
  - Initial led after edge k: mode0 8'h01, mode1 8'h80, mode2 8'hFF, mode3 8'h01.
  - busy=1 after edge k.
- mode is sampled only at start; changes during RUN are ignored.
- speed is shadowed: speed is sampled every cycle into speed_pend. speed_r <= speed_pend only at the edge where the counter wraps, so the current step always completes at the old rate.
- Step timer (RUN only):
  - counter counts 0..Nsel-1, where Nsel is selected by speed_r.
  - At the edge where counter==Nsel-1: counter <= 0, led advances, step_tick <= 1. step_tick is 0 otherwise.
  - First advance occurs Nsel cycles after the start edge; the step period is exactly Nsel cycles.
- Advance rules:
  - mode0: rotate left, bit7 wraps to bit0.
  - mode1: rotate right, bit0 wraps to bit7.
  - mode2: led <= ~led (FF/00 alternate).
  - mode3: shift in dir; at led==8'h80 dir flips to right, at led==8'h01 dir flips to left. The flip is applied the same edge the end bit is shown, so the end LEDs are not held twice. Period is 14 steps.
- stop at edge k: state IDLE, led=8'h00, busy=0, step_tick=0, counter=0 after edge k.
- In IDLE the counter is held at 0 and led is held at 0.
- rst mid-RUN: identical to power-on reset at that edge; a pending start the same cycle is ignored.
- Width: counter compare uses WIDTH-bit constants; N values are truncated to WIDTH bits. Misconfiguration is not checked in RTL; the bench asserts N_* < 2**WIDTH.
- N_* = 1 is legal: tick every cycle while in RUN.

Decomposition:
- led_flash_pkg:
  - state enum (IDLE, RUN)
  - mode encodings (MODE_ROL, MODE_ROR, MODE_BLINK, MODE_PING)
  - speed encodings
  - initial-pattern constants (8'h01, 8'h80, 8'hFF)
- Sub-module step_timer:
  - Ports: clk, rst, clear, en, n (WIDTH), tick.
  - Modulo-n counter with synchronous clear; tick is combinational at count==n-1, which the parent registers as step_tick.
  - led_flash_ctrl instantiates one step_timer and holds the FSM, pattern registers and speed shadow.

Test Plan:
- Reset then start with mode=0, speed=3 (N_TURBO=4) -> led=01 after the start edge; 02,04,…,80,01 every 4 cycles; step_tick pulses every 4th cycle; busy=1.
- mode=3, speed=3, run 16 steps -> led sequence 01,02,…,80,40,…,01,02; period 14 steps; no repeated 80 or 01.
- mode=2, speed=3; at step 2, change speed to 0 mid-step -> the current step completes at 4 cycles, the next step lasts N_SLOW cycles (use overridden N_SLOW=10 in the bench).
- Pulse start and stop in the same cycle while RUN -> next cycle led=00, busy=0, no further step_tick.
- mode=1 running; assert start again with mode=0 -> led=01 after that edge, counter restarted (next advance exactly 4 cycles later, to 02).
- Assert rst for one cycle during RUN with start high in the same cycle -> led=00, busy=0; the block stays IDLE until a fresh start.
